// File: rtl/uart_pkg.sv
// Shared constants and helpers for the configurable UART receiver.
package uart_pkg;

   // Baud_Set encodings
   localparam logic [2:0] BAUD_SEL_9600   = 3'd0;
   localparam logic [2:0] BAUD_SEL_19200  = 3'd1;
   localparam logic [2:0] BAUD_SEL_38400  = 3'd2;
   localparam logic [2:0] BAUD_SEL_57600  = 3'd3;
   localparam logic [2:0] BAUD_SEL_115200 = 3'd4;
   localparam logic [2:0] BAUD_SEL_230400 = 3'd5;
   localparam logic [2:0] BAUD_SEL_460800 = 3'd6;
   localparam logic [2:0] BAUD_SEL_921600 = 3'd7;

   // Line rates in bits per second
   localparam int unsigned BAUD_9600   = 9600;
   localparam int unsigned BAUD_19200  = 19200;
   localparam int unsigned BAUD_38400  = 38400;
   localparam int unsigned BAUD_57600  = 57600;
   localparam int unsigned BAUD_115200 = 115200;
   localparam int unsigned BAUD_230400 = 230400;
   localparam int unsigned BAUD_460800 = 460800;
   localparam int unsigned BAUD_921600 = 921600;

   // parity_mode encodings; the reserved code behaves as no parity
   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;
   localparam logic [1:0] PAR_RSVD = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_DONE
   } rx_state_e;

   // Clock cycles per bit for the selected rate; unknown codes fall back to 115200
   function automatic logic [15:0] bps_div(input int unsigned clk_freq, input logic [2:0] baud_set);
      int unsigned rate;
      case (baud_set)
         BAUD_SEL_9600:   rate = BAUD_9600;
         BAUD_SEL_19200:  rate = BAUD_19200;
         BAUD_SEL_38400:  rate = BAUD_38400;
         BAUD_SEL_57600:  rate = BAUD_57600;
         BAUD_SEL_115200: rate = BAUD_115200;
         BAUD_SEL_230400: rate = BAUD_230400;
         BAUD_SEL_460800: rate = BAUD_460800;
         BAUD_SEL_921600: rate = BAUD_921600;
         default:         rate = BAUD_115200;
      endcase
      return 16'(clk_freq / rate);
   endfunction

   // True when the frame carries a parity bit
   function automatic logic parity_on(input logic [1:0] mode);
      case (mode)
         PAR_EVEN, PAR_ODD:  return 1'b1;
         PAR_NONE, PAR_RSVD: return 1'b0;
         default:            return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Bit-level front end: rx synchronizer, start-edge detect, bit-period
// counter and 3-sample majority vote around mid-bit.
module uart_bit_sampler (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx,
   input  logic [15:0] bps,
   input  logic        cnt_en,
   output logic        start_edge,
   output logic        bit_tick,
   output logic        bit_end,
   output logic        bit_val
);

   logic        sync1_q, sync2_q, prev_q;
   logic [15:0] cnt_q;
   logic        s0_q, s1_q;
   logic [15:0] half;

   assign half = bps >> 1;

   // Two-FF synchronizer plus one history stage for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
      if (!rst_n) begin
         // Reset to the idle-high level so leaving reset never looks like a start edge
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign start_edge = prev_q & ~sync2_q;

   // Bit-period counter; held at zero whenever the receiver is not inside a frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!cnt_en || bit_end) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign bit_end  = cnt_en && (cnt_q == bps - 16'd1);
   assign bit_tick = cnt_en && (cnt_q == half + 16'd1);

   // Capture the two early samples; the third is the live synchronized value at the decision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_q <= 1'b1;
         s1_q <= 1'b1;
      end else begin
         if (cnt_q == half - 16'd1) s0_q <= sync2_q;
         if (cnt_q == half)         s1_q <= sync2_q;
      end
   end

   assign bit_val = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5-8 data bits, optional parity, 1 or 2 stop
// bits, 8 selectable rates. Frame config is latched at the start edge.
module uart_rx_cfg #(
   parameter int unsigned CLK_FREQ = 100000000,
   parameter int unsigned DATA_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        Baud_Set,
   input  logic [1:0]        data_bits,
   input  logic [1:0]        parity_mode,
   input  logic              stop_bits,
   input  logic              rx,
   output logic [DATA_W-1:0] data,
   output logic              rx_valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              rx_busy
);
   import uart_pkg::*;

   rx_state_e         state_q;
   logic [2:0]        baud_q;
   logic [1:0]        bits_q;
   logic [1:0]        par_q;
   logic              stop2_q;
   logic [DATA_W-1:0] shreg_q;
   logic [DATA_W-1:0] data_q;
   logic [2:0]        bit_idx_q;
   logic              stop_idx_q;
   logic              par_acc_q, perr_q, ferr_q;
   logic              rx_valid_q, parity_err_q, frame_err_q, rx_busy_q;

   logic [15:0] bps;
   logic [2:0]  last_idx;
   logic        cnt_en, start_edge, bit_tick, bit_end, bit_val;

   assign bps      = bps_div(CLK_FREQ, baud_q);
   assign last_idx = {1'b0, bits_q} + 3'd4;
   assign cnt_en   = (state_q == ST_START) || (state_q == ST_DATA) ||
                     (state_q == ST_PARITY) || (state_q == ST_STOP);

   uart_bit_sampler u_sampler (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .bps        (bps),
      .cnt_en     (cnt_en),
      .start_edge (start_edge),
      .bit_tick   (bit_tick),
      .bit_end    (bit_end),
      .bit_val    (bit_val)
   );

   // Frame FSM with shift register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         baud_q       <= BAUD_SEL_115200;
         bits_q       <= 2'd3;
         par_q        <= PAR_NONE;
         stop2_q      <= 1'b0;
         shreg_q      <= '0;
         data_q       <= '0;
         bit_idx_q    <= 3'd0;
         stop_idx_q   <= 1'b0;
         par_acc_q    <= 1'b0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
         rx_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         rx_busy_q    <= 1'b0;
      end else begin
         case (state_q)
            // DONE accepts a start edge too, so back-to-back frames lose nothing
            ST_IDLE, ST_DONE: begin
               rx_valid_q <= 1'b0;
               if (start_edge) begin
                  state_q    <= ST_START;
                  rx_busy_q  <= 1'b1;
                  baud_q     <= Baud_Set;
                  bits_q     <= data_bits;
                  par_q      <= parity_mode;
                  stop2_q    <= stop_bits;
                  shreg_q    <= '0;
                  par_acc_q  <= 1'b0;
                  perr_q     <= 1'b0;
                  ferr_q     <= 1'b0;
                  bit_idx_q  <= 3'd0;
                  stop_idx_q <= 1'b0;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_START: begin
               if (bit_tick && bit_val) begin
                  state_q   <= ST_IDLE;
                  rx_busy_q <= 1'b0;
               end else if (bit_end) begin
                  state_q <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_tick) begin
                  shreg_q[bit_idx_q] <= bit_val;
                  par_acc_q          <= par_acc_q ^ bit_val;
               end
               if (bit_end) begin
                  if (bit_idx_q == last_idx) begin
                     state_q <= parity_on(par_q) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end
            end
            ST_PARITY: begin
               if (bit_tick) perr_q <= bit_val != (par_acc_q ^ (par_q == PAR_ODD));
               if (bit_end)  state_q <= ST_STOP;
            end
            // Last stop bit finishes the frame at its mid-bit decision
            ST_STOP: begin
               if (bit_tick) begin
                  if (stop_idx_q == stop2_q) begin
                     state_q      <= ST_DONE;
                     rx_valid_q   <= 1'b1;
                     rx_busy_q    <= 1'b0;
                     data_q       <= shreg_q;
                     parity_err_q <= perr_q;
                     frame_err_q  <= ferr_q | ~bit_val;
                  end else begin
                     ferr_q <= ferr_q | ~bit_val;
                  end
               end else if (bit_end) begin
                  stop_idx_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign data       = data_q;
   assign rx_valid   = rx_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed frames plus a randomized
// sweep, each word compared against a frame-level model of the line protocol.
module tb_uart_rx_cfg;

   // Low clock rate keeps frames short: 921600 baud is 8 clocks per bit
   localparam int unsigned CLK_FREQ = 7372800;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] Baud_Set = 3'd4;
   logic [1:0] data_bits = 2'd3;
   logic [1:0] parity_mode = 2'd0;
   logic       stop_bits = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] data;
   logic       rx_valid, parity_err, frame_err, rx_busy;

   uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .DATA_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .Baud_Set    (Baud_Set),
      .data_bits   (data_bits),
      .parity_mode (parity_mode),
      .stop_bits   (stop_bits),
      .rx          (rx),
      .data        (data),
      .rx_valid    (rx_valid),
      .parity_err  (parity_err),
      .frame_err   (frame_err),
      .rx_busy     (rx_busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      logic       busy;
      int         cyc;
   } rec_t;

   rec_t got_q[$];
   int   busy_rises = 0;
   logic busy_prev  = 1'b0;

   int unsigned rates [8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};

   // current frame configuration as the bench sees it
   int cfg_baud, cfg_bits, cfg_par, cfg_stop;
   // model results of the most recent send
   logic [7:0] m_d;
   logic       m_pe, m_fe;
   int         m_lat, last_start;

   always @(posedge clk) cyc++;

   // Record every word the receiver delivers, and count busy rising edges
   always @(negedge clk) begin
      rec_t r;
      if (rx_valid === 1'b1) begin
         r.d = data; r.pe = parity_err; r.fe = frame_err; r.busy = rx_busy; r.cyc = cyc;
         got_q.push_back(r);
      end
      if (rx_busy === 1'b1 && busy_prev === 1'b0) busy_rises++;
      busy_prev = rx_busy;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int bps_of(input int sel);
      return int'(CLK_FREQ / rates[sel]);
   endfunction

   task automatic set_cfg(input int baud, input int bits, input int par, input int stop);
      cfg_baud = baud; cfg_bits = bits; cfg_par = par; cfg_stop = stop;
      Baud_Set = 3'(baud); data_bits = 2'(bits); parity_mode = 2'(par); stop_bits = 1'(stop);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Serialize one frame from the current config; called on a falling clock edge
   task automatic send(input logic [7:0] d, input bit flip_par, input bit stop_low,
                       input bit spike, input bit scramble);
      logic       bits[$];
      logic [7:0] mask;
      int         b, n, h, p_on, s_cnt;
      b     = bps_of(cfg_baud);
      h     = b / 2;
      n     = cfg_bits + 5;
      p_on  = (cfg_par == 1 || cfg_par == 2) ? 1 : 0;
      s_cnt = cfg_stop + 1;
      mask  = 8'((1 << n) - 1);
      bits.push_back(1'b0);
      for (int i = 0; i < n; i++) bits.push_back(d[i]);
      if (p_on != 0) bits.push_back((^(d & mask)) ^ (cfg_par == 2) ^ flip_par);
      for (int s = 0; s < s_cnt; s++) bits.push_back(!(stop_low && s == 0));
      m_d   = d & mask;
      m_pe  = flip_par && (p_on != 0);
      m_fe  = stop_low;
      m_lat = 2 + (n + p_on + s_cnt) * b + h + 2;
      last_start = cyc + 1;
      for (int j = 0; j < bits.size(); j++) begin
         for (int i = 0; i < b; i++) begin
            rx = bits[j] ^ (spike && j >= 1 && j <= n && i == h + 1);
            @(negedge clk);
         end
         if (scramble && j == 0) begin
            Baud_Set = 3'($urandom); data_bits = 2'($urandom);
            parity_mode = 2'($urandom); stop_bits = 1'($urandom);
         end
      end
      rx = 1'b1;
      Baud_Set = 3'(cfg_baud); data_bits = 2'(cfg_bits);
      parity_mode = 2'(cfg_par); stop_bits = 1'(cfg_stop);
   endtask

   task automatic expect_word(input string tag, input logic [7:0] ed, input logic epe,
                              input logic efe, input bit chk_lat);
      rec_t r;
      for (int i = 0; i < 20000 && got_q.size() == 0; i++) @(negedge clk);
      check({tag, "_seen"}, 32'(got_q.size() != 0), 32'd1);
      if (got_q.size() != 0) begin
         r = got_q.pop_front();
         check({tag, "_data"}, 32'(r.d), 32'(ed));
         check({tag, "_perr"}, 32'(r.pe), 32'(epe));
         check({tag, "_ferr"}, 32'(r.fe), 32'(efe));
         check({tag, "_busy"}, 32'(r.busy), 32'd0);
         if (chk_lat) check({tag, "_lat"}, 32'(r.cyc - last_start), 32'(m_lat));
      end
   endtask

   initial begin
      int b, rises;
      // ---- reset state ----
      set_cfg(4, 3, 0, 0);
      repeat (3) @(negedge clk);
      check("rst_data", 32'(data), 32'd0);
      check("rst_valid", 32'(rx_valid), 32'd0);
      check("rst_perr", 32'(parity_err), 32'd0);
      check("rst_ferr", 32'(frame_err), 32'd0);
      check("rst_busy", 32'(rx_busy), 32'd0);
      rst_n = 1'b1;
      idle(20);
      check("rst_release_quiet", 32'(got_q.size() + busy_rises), 32'd0);

      // ---- 8N1 at 115200 ----
      send(8'hA5, 0, 0, 0, 0);
      expect_word("8n1_a5", 8'hA5, 1'b0, 1'b0, 1'b1);
      idle(10);

      // ---- 7E2 at 9600 ----
      set_cfg(0, 2, 1, 1);
      send(8'h3C, 0, 0, 0, 0);
      expect_word("7e2_3c", 8'h3C, 1'b0, 1'b0, 1'b1);
      send(8'h3D, 0, 0, 0, 0);
      expect_word("7e2_3d", 8'h3D, 1'b0, 1'b0, 1'b0);
      send(8'h3D, 1, 0, 0, 0);
      expect_word("7e2_3d_bad", 8'h3D, 1'b1, 1'b0, 1'b0);
      idle(10);

      // ---- 5O1 at 921600, then 8N1 with stop low ----
      set_cfg(7, 0, 2, 0);
      send(8'h1F, 0, 0, 0, 0);
      expect_word("5o1_1f", 8'h1F, 1'b0, 1'b0, 1'b1);
      idle(10);
      set_cfg(4, 3, 0, 0);
      send(8'h55, 0, 1, 0, 0);
      expect_word("8n1_stoplow", 8'h55, 1'b0, 1'b1, 1'b0);
      idle(20);

      // ---- false start: short low glitch well under half a bit ----
      b = bps_of(4);
      rises = busy_rises;
      rx = 1'b0;
      repeat (b / 4) @(negedge clk);
      check("fs_busy_high", 32'(rx_busy), 32'd1);
      idle(2 * b);
      check("fs_busy_low", 32'(rx_busy), 32'd0);
      check("fs_busy_pulses", 32'(busy_rises - rises), 32'd1);
      check("fs_no_valid", 32'(got_q.size()), 32'd0);
      send(8'h81, 0, 0, 0, 0);
      expect_word("fs_81", 8'h81, 1'b0, 1'b0, 1'b1);
      idle(10);

      // ---- spikes on one of three samples per data bit ----
      send(8'hF0, 0, 0, 1, 0);
      expect_word("spike_f0", 8'hF0, 1'b0, 1'b0, 1'b1);
      idle(10);

      // ---- back-to-back frames, no idle gap ----
      send(8'h3A, 0, 0, 0, 0);
      send(8'hC7, 0, 0, 0, 0);
      expect_word("b2b_first", 8'h3A, 1'b0, 1'b0, 1'b0);
      expect_word("b2b_second", 8'hC7, 1'b0, 1'b0, 1'b1);
      idle(10);

      // ---- reset during data bit 4 of 0xFF ----
      rx = 1'b0;
      repeat (b) @(negedge clk);
      rx = 1'b1;
      repeat (4 * b + b / 2) @(negedge clk);
      check("rr_busy_before", 32'(rx_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rr_data", 32'(data), 32'd0);
      check("rr_valid", 32'(rx_valid), 32'd0);
      check("rr_busy", 32'(rx_busy), 32'd0);
      check("rr_ferr", 32'(frame_err), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(6 * b);
      check("rr_no_valid", 32'(got_q.size()), 32'd0);
      send(8'h12, 0, 0, 0, 0);
      expect_word("rr_12", 8'h12, 1'b0, 1'b0, 1'b1);
      idle(10);

      // ---- break: line held low for several frames ----
      set_cfg(7, 3, 0, 0);
      b = bps_of(7);
      rx = 1'b0;
      repeat (40 * b) @(negedge clk);
      expect_word("break", 8'h00, 1'b0, 1'b1, 1'b0);
      repeat (10 * b) @(negedge clk);
      check("break_single", 32'(got_q.size()), 32'd0);
      idle(2 * b);
      send(8'h5A, 0, 0, 0, 0);
      expect_word("break_rearm", 8'h5A, 1'b0, 1'b0, 1'b1);
      idle(10);

      // ---- randomized frames; config lines scrambled mid-frame ----
      for (int k = 0; k < 12; k++) begin
         logic [7:0] d;
         set_cfg(int'($urandom_range(7, 4)), int'($urandom_range(3, 0)),
                 int'($urandom_range(3, 0)), int'($urandom_range(1, 0)));
         d = 8'($urandom);
         send(d, $urandom_range(2, 0) == 0, $urandom_range(3, 0) == 0, 0, k[0]);
         expect_word($sformatf("rnd%0d", k), m_d, m_pe, m_fe, 1'b1);
         idle(int'($urandom_range(12, 3)));
      end
      check("final_no_extra", 32'(got_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
